// File: rtl/date_countdown.sv
// date_countdown
//   BCD calendar down-counter for DD-MM-YY, years 2000-2099. It feeds the
//   countdown and "days remaining" displays. The neighbouring time-of-day
//   countdown drives dec_enable[0] with its day borrow.
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset (date 01-01-00)
//   dec_enable[2:0]     [0] date (borrows into month/year), [1] month, [2] year
//   load_value_enable   load the six load_value_* digits (highest priority)
//   load_value_*        BCD load digits, sanitised before they are stored
//   date1/date0         current date, BCD tens/units
//   month1/month0       current month, BCD tens/units
//   year1/year0         current year, BCD tens/units
//   underflow           one-cycle pulse on the 00-01-01 -> 99-12-31 wrap
//
// Each cycle carries out at most one action. Its priority is load, then
// date, then month, then year. Lower-priority strobes in the same cycle are
// dropped. The arithmetic runs on small binary values that are decoded from
// the BCD registers. The results are re-encoded before they are registered.

`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif

module date_countdown (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2:0]                dec_enable,
    input  logic                      load_value_enable,
    input  logic [`BCD_BIT_WIDTH-1:0] load_value_date0,
    input  logic [`BCD_BIT_WIDTH-1:0] load_value_date1,
    input  logic [`BCD_BIT_WIDTH-1:0] load_value_month0,
    input  logic [`BCD_BIT_WIDTH-1:0] load_value_month1,
    input  logic [`BCD_BIT_WIDTH-1:0] load_value_year0,
    input  logic [`BCD_BIT_WIDTH-1:0] load_value_year1,
    output logic [`BCD_BIT_WIDTH-1:0] date0,
    output logic [`BCD_BIT_WIDTH-1:0] date1,
    output logic [`BCD_BIT_WIDTH-1:0] month0,
    output logic [`BCD_BIT_WIDTH-1:0] month1,
    output logic [`BCD_BIT_WIDTH-1:0] year0,
    output logic [`BCD_BIT_WIDTH-1:0] year1,
    output logic                      underflow
);

    localparam int W = `BCD_BIT_WIDTH;

    function automatic logic [6:0] bcd_to_bin(input logic [W-1:0] tens,
                                              input logic [W-1:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

    function automatic logic [2*W-1:0] bin_to_bcd(input logic [6:0] value);
        return {W'(value / 7'd10), W'(value % 7'd10)};
    endfunction

    function automatic logic [W-1:0] fix_digit(input logic [W-1:0] digit);
        return (digit > W'(9)) ? '0 : digit;
    endfunction

    // Within 2000-2099 the century rule never applies, so divisible-by-4
    // is exactly the leap rule.
    function automatic logic is_leap(input logic [6:0] year);
        return (year % 7'd4) == 7'd0;
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] month,
                                             input logic       leap);
        logic [4:0] len;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
            4'd2:                    len = leap ? 5'd29 : 5'd28;
            default:                 len = 5'd31;
        endcase
        return len;
    endfunction

    logic [4:0]     cur_date;
    logic [3:0]     cur_month;
    logic [6:0]     cur_year;
    logic [4:0]     next_date;
    logic [3:0]     next_month;
    logic [6:0]     next_year;
    logic           next_underflow;
    logic [4:0]     len_tmp;
    logic [6:0]     ld_date;
    logic [6:0]     ld_month;
    logic [6:0]     ld_year;
    logic [2*W-1:0] date_bcd;
    logic [2*W-1:0] month_bcd;
    logic [2*W-1:0] year_bcd;

    assign cur_date  = 5'(bcd_to_bin(date1, date0));
    assign cur_month = 4'(bcd_to_bin(month1, month0));
    assign cur_year  = bcd_to_bin(year1, year0);

    always_comb begin
        next_date      = cur_date;
        next_month     = cur_month;
        next_year      = cur_year;
        next_underflow = 1'b0;
        len_tmp        = '0;
        ld_date  = bcd_to_bin(fix_digit(load_value_date1),  fix_digit(load_value_date0));
        ld_month = bcd_to_bin(fix_digit(load_value_month1), fix_digit(load_value_month0));
        ld_year  = bcd_to_bin(fix_digit(load_value_year1),  fix_digit(load_value_year0));

        if (load_value_enable) begin
            if (ld_month == 7'd0 || ld_month > 7'd12) ld_month = 7'd1;
            if (ld_date == 7'd0) ld_date = 7'd1;
            len_tmp = month_len(4'(ld_month), is_leap(ld_year));
            if (ld_date > 7'(len_tmp)) ld_date = 7'(len_tmp);
            next_date  = 5'(ld_date);
            next_month = 4'(ld_month);
            next_year  = ld_year;
        end else if (dec_enable[0]) begin
            if (cur_date > 5'd1) begin
                next_date = cur_date - 5'd1;
            end else if (cur_month > 4'd1) begin
                next_month = cur_month - 4'd1;
                next_date  = month_len(cur_month - 4'd1, is_leap(cur_year));
            end else begin
                next_month = 4'd12;
                next_date  = 5'd31;
                if (cur_year == 7'd0) begin
                    next_year      = 7'd99;
                    next_underflow = 1'b1;
                end else begin
                    next_year = cur_year - 7'd1;
                end
            end
        end else if (dec_enable[1]) begin
            next_month = (cur_month == 4'd1) ? 4'd12 : cur_month - 4'd1;
            len_tmp    = month_len(next_month, is_leap(cur_year));
            if (cur_date > len_tmp) next_date = len_tmp;
        end else if (dec_enable[2]) begin
            next_year = (cur_year == 7'd0) ? 7'd99 : cur_year - 7'd1;
            // Only February depends on the year; this clamps 29-02 to 28-02.
            len_tmp   = month_len(cur_month, is_leap(next_year));
            if (cur_date > len_tmp) next_date = len_tmp;
        end
    end

    assign date_bcd  = bin_to_bcd(7'(next_date));
    assign month_bcd = bin_to_bcd(7'(next_month));
    assign year_bcd  = bin_to_bcd(next_year);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            date1     <= W'(0);
            date0     <= W'(1);
            month1    <= W'(0);
            month0    <= W'(1);
            year1     <= W'(0);
            year0     <= W'(0);
            underflow <= 1'b0;
        end else begin
            date1     <= date_bcd[2*W-1:W];
            date0     <= date_bcd[W-1:0];
            month1    <= month_bcd[2*W-1:W];
            month0    <= month_bcd[W-1:0];
            year1     <= year_bcd[2*W-1:W];
            year0     <= year_bcd[W-1:0];
            underflow <= next_underflow;
        end
    end

endmodule

// File: tb/tb_date_countdown.sv
// Testbench for date_countdown. It first applies a table of directed
// vectors. It then runs a hand-written asynchronous reset sequence. Last
// comes a randomized run that is checked against a day-index calendar
// model. Dates are packed as {d1,d0,m1,m0,y1,y0} in 24 bits.

module tb_date_countdown;

    logic        clk;
    logic        rst_n;
    logic [2:0]  dec_enable;
    logic        load_value_enable;
    logic [23:0] ld_bus;
    logic [3:0]  date0, date1, month0, month1, year0, year1;
    logic        underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    date_countdown dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dec_enable        (dec_enable),
        .load_value_enable (load_value_enable),
        .load_value_date0  (ld_bus[19:16]),
        .load_value_date1  (ld_bus[23:20]),
        .load_value_month0 (ld_bus[11:8]),
        .load_value_month1 (ld_bus[15:12]),
        .load_value_year0  (ld_bus[3:0]),
        .load_value_year1  (ld_bus[7:4]),
        .date0             (date0),
        .date1             (date1),
        .month0            (month0),
        .month1            (month1),
        .year0             (year0),
        .year1             (year1),
        .underflow         (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        load;
        logic [23:0] ld;
        logic [2:0]  dec;
        logic [23:0] exp;
        logic        exp_uf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string name, logic load, logic [23:0] ld,
                                logic [2:0] dec, logic [23:0] exp, logic exp_uf);
        vec_t v;
        v.name = name; v.load = load; v.ld = ld; v.dec = dec;
        v.exp = exp; v.exp_uf = exp_uf;
        vecs.push_back(v);
    endfunction

    function automatic logic [23:0] dut_date();
        return {date1, date0, month1, month0, year1, year0};
    endfunction

    task automatic check(string name, logic [23:0] exp, logic exp_uf);
        logic [23:0] got;
        got = dut_date();
        tests_run++;
        if (got !== exp || underflow !== exp_uf) begin
            tests_failed++;
            $display("FAIL %s: got date %h uf %b, expected date %h uf %b",
                     name, got, underflow, exp, exp_uf);
        end
    endtask

    // Reference calendar model. It works on whole dates and a day index
    // since 01-01-2000.
    int md, mm, my;
    logic m_uf;

    function automatic bit leap_year(int y);
        int t, u;
        t = y / 10;
        u = y % 10;
        return ((t % 2 == 0) && (u == 0 || u == 4 || u == 8)) ||
               ((t % 2 == 1) && (u == 2 || u == 6));
    endfunction

    function automatic int days_in_month(int m, int y);
        int table31[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && leap_year(y)) return 29;
        return table31[m];
    endfunction

    function automatic int day_index(int d, int m, int y);
        int idx = 0;
        for (int i = 0; i < y; i++) idx += leap_year(i) ? 366 : 365;
        for (int i = 1; i < m; i++) idx += days_in_month(i, y);
        return idx + d - 1;
    endfunction

    task automatic from_index(input int idx);
        int y = 0;
        int m = 1;
        while (idx >= (leap_year(y) ? 366 : 365)) begin
            idx -= leap_year(y) ? 366 : 365;
            y++;
        end
        while (idx >= days_in_month(m, y)) begin
            idx -= days_in_month(m, y);
            m++;
        end
        md = idx + 1; mm = m; my = y;
    endtask

    function automatic int digit(logic [3:0] v);
        return (v > 9) ? 0 : int'(v);
    endfunction

    function automatic logic [23:0] pack(int d, int m, int y);
        return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10), 4'(y / 10), 4'(y % 10)};
    endfunction

    task automatic model_step(input logic load, input logic [23:0] ld, input logic [2:0] dec);
        int idx;
        m_uf = 1'b0;
        if (load) begin
            my = digit(ld[7:4]) * 10 + digit(ld[3:0]);
            mm = digit(ld[15:12]) * 10 + digit(ld[11:8]);
            md = digit(ld[23:20]) * 10 + digit(ld[19:16]);
            if (mm == 0 || mm > 12) mm = 1;
            if (md == 0) md = 1;
            if (md > days_in_month(mm, my)) md = days_in_month(mm, my);
        end else if (dec[0]) begin
            idx = day_index(md, mm, my);
            if (idx == 0) begin
                idx  = 36524;
                m_uf = 1'b1;
            end else begin
                idx--;
            end
            from_index(idx);
        end else if (dec[1]) begin
            mm = (mm == 1) ? 12 : mm - 1;
            if (md > days_in_month(mm, my)) md = days_in_month(mm, my);
        end else if (dec[2]) begin
            my = (my == 0) ? 99 : my - 1;
            if (md > days_in_month(mm, my)) md = days_in_month(mm, my);
        end
    endtask

    initial begin
        logic [23:0] rnd_ld;
        logic [2:0]  rnd_dec;
        logic        rnd_load;

        rst_n = 1'b0;
        dec_enable = 3'b000;
        load_value_enable = 1'b0;
        ld_bus = '0;

        add("wrap_dec",      0, 24'h0,      3'b001, 24'h311299, 1);
        add("wrap_uf_clear", 0, 24'h0,      3'b000, 24'h311299, 0);
        add("load_010324",   1, 24'h010324, 3'b000, 24'h010324, 0);
        add("feb_leap24",    0, 24'h0,      3'b001, 24'h290224, 0);
        add("load_010323",   1, 24'h010323, 3'b000, 24'h010323, 0);
        add("feb_nonleap23", 0, 24'h0,      3'b001, 24'h280223, 0);
        add("load_010300",   1, 24'h010300, 3'b000, 24'h010300, 0);
        add("feb_leap00",    0, 24'h0,      3'b001, 24'h290200, 0);
        add("load_310521",   1, 24'h310521, 3'b000, 24'h310521, 0);
        add("mdec_apr",      0, 24'h0,      3'b010, 24'h300421, 0);
        add("mdec_mar",      0, 24'h0,      3'b010, 24'h300321, 0);
        add("mdec_feb",      0, 24'h0,      3'b010, 24'h280221, 0);
        add("mdec_jan",      0, 24'h0,      3'b010, 24'h280121, 0);
        add("mdec_wrap",     0, 24'h0,      3'b010, 24'h281221, 0);
        add("load_290224",   1, 24'h290224, 3'b000, 24'h290224, 0);
        add("ydec_clamp",    0, 24'h0,      3'b100, 24'h280223, 0);
        add("load_150600",   1, 24'h150600, 3'b000, 24'h150600, 0);
        add("ydec_wrap",     0, 24'h0,      3'b100, 24'h150699, 0);
        add("load_raw",      1, 24'h3515A3, 3'b000, 24'h310103, 0);
        add("load_date00",   1, 24'h000201, 3'b000, 24'h010201, 0);
        add("load_20",       1, 24'h200110, 3'b000, 24'h200110, 0);
        add("borrow_20_19",  0, 24'h0,      3'b001, 24'h190110, 0);
        add("load_010110",   1, 24'h010110, 3'b000, 24'h010110, 0);
        add("year_borrow",   0, 24'h0,      3'b001, 24'h311209, 0);
        add("load_over_dec", 1, 24'h101010, 3'b111, 24'h101010, 0);
        add("month_over_yr", 0, 24'h0,      3'b110, 24'h100910, 0);

        repeat (2) @(negedge clk);
        check("reset_state", 24'h010100, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            load_value_enable = vecs[i].load;
            ld_bus            = vecs[i].ld;
            dec_enable        = vecs[i].dec;
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].exp, vecs[i].exp_uf);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a strobe
        load_value_enable = 1'b0;
        dec_enable = 3'b001;
        #2 rst_n = 1'b0;
        #1 check("async_reset", 24'h010100, 1'b0);
        @(posedge clk);
        #1 check("reset_held", 24'h010100, 1'b0);
        @(negedge clk);
        dec_enable = 3'b000;
        rst_n = 1'b1;

        md = 1; mm = 1; my = 0; m_uf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rnd_load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                rnd_load = 1'b1;
                rnd_ld   = 24'h010100;
            end else if ($urandom_range(0, 3) == 0) begin
                rnd_ld = 24'($urandom);
            end else begin
                rnd_ld = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)),
                          4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            rnd_dec = 3'($urandom_range(0, 7));
            load_value_enable = rnd_load;
            ld_bus            = rnd_ld;
            dec_enable        = rnd_dec;
            model_step(rnd_load, rnd_ld, rnd_dec);
            @(posedge clk);
            #1;
            check("random", pack(md, mm, my), m_uf);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/date_countdown.md
Name: date_countdown

Overview:
- BCD calendar down-counter (DD-MM-YY, years 2000-2099). Same register interface as the up-counting date unit, counting the other direction.
- Feeds countdown and "days remaining" displays.
- Sits beside the time-of-day countdown. That block's day borrow drives dec_enable[0].
- Handles month lengths, leap years, load-value sanitising and date clamping.

Parameters:
- None. Digit width is the global BCD_BIT_WIDTH define (4).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
dec_enable  input  3  decrement strobes: [0] date (borrows into month/year), [1] month only, [2] year only
load_value_enable  input  1  load the six load_value digits
load_value_date0  input  4  BCD date units
load_value_date1  input  4  BCD date tens
load_value_month0  input  4  BCD month units
load_value_month1  input  4  BCD month tens
load_value_year0  input  4  BCD year units
load_value_year1  input  4  BCD year tens
date0, date1  output  4 each  current date, BCD
month0, month1  output  4 each  current month, BCD
year0, year1  output  4 each  current year, BCD
underflow  output  1  one-cycle pulse when 00-01-01 wraps to 99-12-31

Behaviour:
Reset and output timing:
- Reset (async, rst_n low): date 01, month 01, year 00, underflow 0.
- All outputs are registered. Every action takes effect on the clock edge where it is sampled. Latency is 1 cycle.

Priority per cycle:
- Order: load_value_enable > dec_enable[0] > dec_enable[1] > dec_enable[2]. Only one action per cycle. Lower-priority strobes in the same cycle are dropped, not queued.

Month length (combinational from the current or target month/year):
- 31 days: 01 03 05 07 08 10 12.
- 30 days: 04 06 09 11.
- February: 29 if leap, else 28.
- Leap year means (year1 even and year0 in {0,4,8}) or (year1 odd and year0 in {2,6}). Year 00 is leap.

dec_enable[0] (date decrement):
- date > 01: date - 1, BCD borrow (e.g. 10 -> 09, 20 -> 19).
- date == 01, month > 01: month - 1; date = last day of the new month in the current year.
- date == 01, month == 01, year > 00: month 12, date 31, year - 1 (BCD borrow, e.g. 10 -> 09).
- 00-01-01: wraps to 99-12-31; underflow pulses high for exactly that cycle.

dec_enable[1] (month decrement):
- month - 1; 01 wraps to 12, year unchanged, no underflow.
- Date is then clamped to the new month's length (e.g. 31-03 -> 29-02 in leap year, 28-02 otherwise).

dec_enable[2] (year decrement):
- year - 1; 00 wraps to 99, no underflow.
- Date 29-02 becomes 28-02 when the new year is non-leap.

Load sanitising (applied on load, in this order):
- Any non-BCD digit (>9) is treated as 0 for that digit.
- Month 00 or > 12 loads as 01.
- Date 00 loads as 01.
- Date greater than the length of the loaded month and loaded year loads as that month's last day.
- Year is always accepted after digit fixing.

Invariants:
- The output date is always a valid calendar date, including one cycle after reset.
- underflow is 0 in every cycle except the wrap cycle.

Reset mid-operation:
- Asynchronous reset overrides any load or strobe immediately. No pending state survives reset.

Test Plan:
1. Reset then one dec_enable[0] pulse -> 31-12-99 and underflow=1 for one cycle; next cycle underflow=0.
2. Load 01-03-24, pulse dec_enable[0] -> 29-02-24. Load 01-03-23, pulse dec_enable[0] -> 28-02-23. Load 01-03-00, pulse dec_enable[0] -> 29-02-00.
3. Load 31-05-21, pulse dec_enable[1] -> 30-04-21. Pulse dec_enable[1] three more times -> 28-01-21; a fourth pulse -> 28-12-21.
4. Load 29-02-24, pulse dec_enable[2] -> 29-02-23 is illegal, so the output must be 28-02-23. Load 15-06-00, pulse dec_enable[2] -> 15-06-99, underflow stays 0.
5. Load raw digits date=3,5 (35), month=1,5 (15), year=A,3 -> 31-01-03. Load date 00, month 02, year 01 -> 01-02-01.
6. Same cycle: load_value_enable with 10-10-10 and dec_enable=3'b111 -> 10-10-10 exactly. Then dec_enable=3'b110 for one cycle -> 10-09-10 only (year untouched). Assert rst_n low mid-sequence -> immediately 01-01-00.
